// File: rtl/vga_plot_sink.sv
// -----------------------------------------------------------------------------
// vga_plot_sink
//
// Receiving end of the pixel-plot interface. Plot commands (VGA_X, VGA_Y,
// VGA_COLOR, plot) are buffered in a small FIFO and written into a
// H_RES x V_RES x 3-bit framebuffer. A synchronous read port serves scan-out.
// After reset the whole framebuffer is swept to CLEAR_COLOR before any plot
// is accepted. Off-screen plots are dropped and counted.
//
// Optional feature macro: VGA_PLOT_SINK_CLEAR_REQ_EN
//   When defined, adds input clear_req. A request seen outside the clear
//   sweep blocks new plots, lets the FIFO drain, then re-runs the sweep.
//
// Ports:
//   CLOCK_50    in   1   sole clock, rising edge
//   resetn      in   1   asynchronous active-low reset
//   VGA_X       in   8   plot x coordinate
//   VGA_Y       in   7   plot y coordinate
//   VGA_COLOR   in   3   plot colour
//   plot        in   1   write request, qualified by ready
//   clear_req   in   1   (macro only) request a framebuffer clear
//   ready       out  1   a plot can be accepted this cycle
//   busy        out  1   clear sweep running or FIFO non-empty
//   clip_count  out  8   saturating count of rejected off-screen plots
//   rd_addr     in   15  scan-out read address (y*H_RES+x)
//   rd_data     out  3   colour at rd_addr, one cycle latency
// -----------------------------------------------------------------------------
module vga_plot_sink #(
  parameter int unsigned H_RES       = 160,
  parameter int unsigned V_RES       = 120,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  VGA_X,
  input  logic [6:0]  VGA_Y,
  input  logic [2:0]  VGA_COLOR,
  input  logic        plot,
`ifdef VGA_PLOT_SINK_CLEAR_REQ_EN
  input  logic        clear_req,
`endif
  output logic        ready,
  output logic        busy,
  output logic [7:0]  clip_count,
  input  logic [14:0] rd_addr,
  output logic [2:0]  rd_data
);

  localparam int unsigned NPix     = H_RES * V_RES;
  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [14:0] LastAddr = 15'(NPix - 1);
  localparam logic [14:0] NPixAddr = 15'(NPix);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StDrain
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_e        r_state;
  state_e        w_state_next;
  logic [14:0]   r_clear_addr;
  logic [7:0]    r_clip_count;
  logic [2:0]    r_rd_data;

  // FIFO entry: {framebuffer address, colour}
  logic [17:0]   r_fifo_mem [FIFO_DEPTH];
  logic [PtrW:0] r_wr_ptr;
  logic [PtrW:0] r_rd_ptr;
  logic [PtrW:0] w_count;
  logic [PtrW:0] w_count_next;
  logic          w_full;
  logic          w_empty;
  logic [17:0]   w_head;

  logic          w_onscreen;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_clip;
  logic [14:0]   w_plot_addr;
  logic          w_clear_hold;

  logic          w_we;
  logic [14:0]   w_waddr;
  logic [2:0]    w_wdata;

  logic [2:0]    r_fb [NPix];

  // ---------------------------------------------------------------------------
  // Optional clear request
  // ---------------------------------------------------------------------------
`ifdef VGA_PLOT_SINK_CLEAR_REQ_EN
  logic r_clear_pend;

  // The request is remembered until the sweep actually starts, since the FIFO
  // may need several cycles to drain first.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_clear_pend <= 1'b0;
    end else if (w_state_next == StClear) begin
      r_clear_pend <= 1'b0;
    end else if (clear_req && (r_state != StClear)) begin
      r_clear_pend <= 1'b1;
    end
  end

  // Live request term makes ready fall in the same cycle clear_req rises.
  assign w_clear_hold = (r_state != StClear) && (clear_req || r_clear_pend);
`else
  assign w_clear_hold = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Plot decode and FIFO status
  // ---------------------------------------------------------------------------
  assign w_onscreen  = (32'(VGA_X) < H_RES) && (32'(VGA_Y) < V_RES);
  // Constant multiply reduces to (y<<7)+(y<<5)+x for the default 160 width.
  assign w_plot_addr = (15'(H_RES) * {8'd0, VGA_Y}) + {7'd0, VGA_X};
  assign w_accept    = plot && ready;
  assign w_push      = w_accept && w_onscreen;
  assign w_clip      = w_accept && !w_onscreen;

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_count == FullCnt);
  assign w_empty      = (w_count == '0);
  assign w_head       = r_fifo_mem[r_rd_ptr[PtrW-1:0]];
  assign w_count_next = w_count + {{PtrW{1'b0}}, w_push} - {{PtrW{1'b0}}, w_pop};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= StClear;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StClear: begin
        if (r_clear_addr == LastAddr) begin
          w_state_next = StIdle;
        end
      end
      StIdle, StDrain: begin
        // Drain always wins; a pending clear waits for an empty FIFO.
        if (w_count_next != '0) begin
          w_state_next = StDrain;
        end else if (w_clear_hold) begin
          w_state_next = StClear;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StClear;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and framebuffer write port
  // ---------------------------------------------------------------------------
  always_comb begin
    ready   = (r_state != StClear) && !w_full && !w_clear_hold;
    busy    = (r_state == StClear) || !w_empty;
    w_pop   = (r_state == StDrain) && !w_empty;
    w_we    = 1'b0;
    w_waddr = w_head[17:3];
    w_wdata = w_head[2:0];
    if (r_state == StClear) begin
      w_we    = 1'b1;
      w_waddr = r_clear_addr;
      w_wdata = CLEAR_COLOR;
    end else if (w_pop) begin
      w_we    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sweep address: counts only inside CLEAR, parked at 0 otherwise so
  // any later entry into CLEAR starts from the first pixel.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_clear_addr <= '0;
    end else if ((r_state == StClear) && (r_clear_addr != LastAddr)) begin
      r_clear_addr <= r_clear_addr + 15'd1;
    end else begin
      r_clear_addr <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Plot FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[PtrW-1:0]] <= {w_plot_addr, VGA_COLOR};
    end
  end

  // ---------------------------------------------------------------------------
  // Clip counter, saturating
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_clip_count <= '0;
    end else if (w_clip && (r_clip_count != 8'hFF)) begin
      r_clip_count <= r_clip_count + 8'd1;
    end
  end

  assign clip_count = r_clip_count;

  // ---------------------------------------------------------------------------
  // Framebuffer: simple dual-port RAM, read-before-write on address collision
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (w_we) begin
      r_fb[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_rd_data <= '0;
    end else if (rd_addr < NPixAddr) begin
      r_rd_data <= r_fb[rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_vga_plot_sink.sv
// -----------------------------------------------------------------------------
// Testbench for vga_plot_sink. Keeps a pixel-array model of the framebuffer and
// a saturating clip counter, updated per accepted plot, and compares reads,
// handshake outputs and sweep length against it.
// -----------------------------------------------------------------------------
module tb_vga_plot_sink;

  localparam int NPIX = 160 * 120;

  logic        CLOCK_50;
  logic        resetn;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [2:0]  VGA_COLOR;
  logic        plot;
  logic        ready;
  logic        busy;
  logic [7:0]  clip_count;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
`ifdef VGA_PLOT_SINK_CLEAR_REQ_EN
  logic        clear_req;
`endif

  vga_plot_sink dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .VGA_X      (VGA_X),
    .VGA_Y      (VGA_Y),
    .VGA_COLOR  (VGA_COLOR),
    .plot       (plot),
`ifdef VGA_PLOT_SINK_CLEAR_REQ_EN
    .clear_req  (clear_req),
`endif
    .ready      (ready),
    .busy       (busy),
    .clip_count (clip_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] model_fb [NPIX];
  int         model_clip = 0;
  int         touched [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NPIX; i++) model_fb[i] = 3'b000;
  endtask

  // Wait for the sweep to end; expects exactly 19200 cycles of ready=0/busy=1.
  task automatic wait_clear(input string tag, input int lo, input int hi);
    int n = 0;
    int busy_low = 0;
    while (ready !== 1'b1 && n < 20000) begin
      if (busy !== 1'b1) busy_low++;
      tick();
      n++;
    end
    check({tag, "_len_lo"}, 32'(n >= lo), 32'd1);
    check({tag, "_len_hi"}, 32'(n <= hi), 32'd1);
    check({tag, "_busy_during"}, 32'(busy_low), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic read_px(input int a, output logic [2:0] d);
    rd_addr = 15'(a);
    tick();
    d = rd_data;
  endtask

  task automatic check_px(input string tag, input int a);
    logic [2:0] d;
    logic [2:0] e;
    read_px(a, d);
    e = (a < NPIX) ? model_fb[a] : 3'b000;
    check(tag, 32'(d), 32'(e));
  endtask

  task automatic model_plot(input int x, input int y, input int c);
    if (x < 160 && y < 120) begin
      model_fb[y * 160 + x] = 3'(c);
      touched.push_back(y * 160 + x);
    end else if (model_clip < 255) begin
      model_clip++;
    end
  endtask

  // One single-cycle plot; the sink is expected ready at this point.
  task automatic plot_one(input int x, input int y, input int c);
    VGA_X = 8'(x);
    VGA_Y = 7'(y);
    VGA_COLOR = 3'(c);
    plot = 1'b1;
    check("ready_before_plot", 32'(ready), 32'd1);
    tick();
    plot = 1'b0;
    model_plot(x, y, c);
  endtask

  initial begin
    logic [2:0] d;
    resetn = 1'b0;
    plot = 1'b0;
    VGA_X = '0;
    VGA_Y = '0;
    VGA_COLOR = '0;
    rd_addr = '0;
`ifdef VGA_PLOT_SINK_CLEAR_REQ_EN
    clear_req = 1'b0;
`endif
    model_clear();

    // Reset values
    tick();
    tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_clip", 32'(clip_count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    resetn = 1'b1;

    wait_clear("clear0", 19200, 19200);
    check_px("clr_px0", 0);
    check_px("clr_px9600", 9600);
    check_px("clr_px19199", 19199);
    check_px("rd_out_of_range", 19200);

    // Single plot with latency and read-during-write behaviour
    plot_one(5, 2, 5);
    rd_addr = 15'd325;
    tick();
    check("rdw_old_data", 32'(rd_data), 32'd0);
    tick();
    check("plot_5_2", 32'(rd_data), 32'd5);
    check("clip_after_plot", 32'(clip_count), 32'd0);

    // Off-screen boundaries
    plot_one(160, 0, 3);
    plot_one(0, 120, 4);
    plot_one(200, 119, 6);
    tick();
    check("clip_three", 32'(clip_count), 32'(model_clip));
    check_px("clip_px0", 0);
    check_px("clip_px19199", 19199);
    check_px("clip_px_last_col", 159);

    // Randomised plots with random gaps, including off-screen coordinates
    for (int i = 0; i < 150; i++) begin
      int gap;
      plot_one(int'($urandom_range(0, 199)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
    end
    tick();
    tick();
    check("rand_clip", 32'(clip_count), 32'(model_clip));
    check("rand_busy_idle", 32'(busy), 32'd0);
    foreach (touched[i]) check_px("rand_px", touched[i]);
    for (int i = 0; i < 20; i++) check_px("rand_any_px", int'($urandom_range(0, NPIX - 1)));

    // Back-to-back burst: push and pop balance so ready never drops
    for (int i = 0; i < 10; i++) begin
      VGA_X = 8'(i);
      VGA_Y = 7'd119;
      VGA_COLOR = 3'((i % 7) + 1);
      plot = 1'b1;
      check("burst_ready", 32'(ready), 32'd1);
      tick();
      model_plot(i, 119, (i % 7) + 1);
    end
    plot = 1'b0;
    tick();
    for (int a = 19040; a < 19050; a++) check_px("burst_px", a);

    // Saturation of the clip counter
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) plot_one(int'($urandom_range(160, 255)), int'($urandom_range(0, 127)), 1);
      else plot_one(int'($urandom_range(0, 159)), int'($urandom_range(120, 127)), 2);
    end
    tick();
    check("clip_saturated", 32'(clip_count), 32'd255);
    check("clip_model_sat", 32'(model_clip), 32'd255);

    // Reset in the middle of a drain
    plot_one(7, 7, 6);
    tick();
    check_px("pre_reset_px", 7 * 160 + 7);
    plot_one(8, 8, 2);
    resetn = 1'b0;
    #2;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_clip", 32'(clip_count), 32'd0);
    tick();
    resetn = 1'b1;
    model_clear();
    model_clip = 0;
    check("post_rst_ready", 32'(ready), 32'd0);
    wait_clear("clear1", 19200, 19200);
    check_px("post_rst_px_7_7", 7 * 160 + 7);
    check_px("post_rst_px_8_8", 8 * 160 + 8);
    check("post_rst_clip", 32'(clip_count), 32'd0);

`ifdef VGA_PLOT_SINK_CLEAR_REQ_EN
    // Requested clear: drain first, then full sweep
    plot_one(1, 1, 7);
    clear_req = 1'b1;
    #1;
    check("creq_ready_drop", 32'(ready), 32'd0);
    tick();
    clear_req = 1'b0;
    check("creq_busy", 32'(busy), 32'd1);
    model_clear();
    wait_clear("clear_req", 19200, 19202);
    check_px("creq_px161", 161);
    check("creq_clip", 32'(clip_count), 32'(model_clip));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
